// File: rtl/ddr3_sched_pkg.sv
// Shared widths, command/state enums and pin encodings for the
// mt41j64m16 DDR3 command scheduler.
package ddr3_sched_pkg;

    localparam int BANK_W = 3;
    localparam int ROW_W  = 14;
    localparam int COL_W  = 10;
    localparam int NBANK  = 8;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_PREA,
        CMD_REF,
        CMD_DES
    } cmd_e;

    // {csbar, rasbar, casbar, webar}
    localparam logic [3:0] ENC_NOP = 4'b0111;
    localparam logic [3:0] ENC_ACT = 4'b0011;
    localparam logic [3:0] ENC_RD  = 4'b0101;
    localparam logic [3:0] ENC_WR  = 4'b0100;
    localparam logic [3:0] ENC_PRE = 4'b0010;
    localparam logic [3:0] ENC_REF = 4'b0001;
    localparam logic [3:0] ENC_DES = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_COL,
        S_PREA,
        S_REF,
        S_RFC_WAIT
    } state_e;

    typedef struct packed {
        logic             write;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } req_t;

    function automatic logic [3:0] cmd_enc(input cmd_e c);
        logic [3:0] e;
        e = ENC_NOP;
        case (c)
            CMD_ACT:  e = ENC_ACT;
            CMD_RD:   e = ENC_RD;
            CMD_WR:   e = ENC_WR;
            CMD_PRE:  e = ENC_PRE;
            CMD_PREA: e = ENC_PRE;
            CMD_REF:  e = ENC_REF;
            CMD_DES:  e = ENC_DES;
            default:  e = ENC_NOP;
        endcase
        return e;
    endfunction

    function automatic int tmax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/ddr3_bank_timer.sv
// Per-bank open-row tracker with ACT/RD-WR/PRE readiness down-counters.
// Counters load (T-1) on the issuing strobe so "ok" means legal next cycle.
module ddr3_bank_timer
    import ddr3_sched_pkg::*;
#(
    parameter int T_RCD = 5,
    parameter int T_RP  = 5,
    parameter int T_RAS = 14,
    parameter int T_RTP = 4,
    parameter int T_WTP = 17,
    parameter int CW    = 5
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             act,
    input  logic             rd,
    input  logic             wr,
    input  logic             pre,
    input  logic [ROW_W-1:0] act_row,
    output logic             is_open,
    output logic [ROW_W-1:0] row,
    output logic             act_ok,
    output logic             rw_ok,
    output logic             pre_ok
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] L_RAS = CW'(T_RAS - 1);
    localparam logic [CW-1:0] L_RTP = CW'(T_RTP - 1);
    localparam logic [CW-1:0] L_WTP = CW'(T_WTP - 1);

    logic [CW-1:0] act_cnt;
    logic [CW-1:0] rw_cnt;
    logic [CW-1:0] pre_cnt;
    logic [CW-1:0] act_dec;
    logic [CW-1:0] rw_dec;
    logic [CW-1:0] pre_dec;
    logic [CW-1:0] pre_nxt;

    // pre_cnt keeps the longest outstanding ACT/RD/WR-to-PRE constraint
    always_comb begin
        act_dec = (act_cnt == '0) ? '0 : act_cnt - ONE;
        rw_dec  = (rw_cnt == '0) ? '0 : rw_cnt - ONE;
        pre_dec = (pre_cnt == '0) ? '0 : pre_cnt - ONE;
        pre_nxt = pre_dec;
        if (act)
            pre_nxt = L_RAS;
        else if (rd && pre_dec < L_RTP)
            pre_nxt = L_RTP;
        else if (wr && pre_dec < L_WTP)
            pre_nxt = L_WTP;
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            act_cnt <= '0;
            rw_cnt  <= '0;
            pre_cnt <= '0;
            is_open <= 1'b0;
            row     <= '0;
        end else begin
            act_cnt <= pre ? L_RP : act_dec;
            rw_cnt  <= act ? L_RCD : rw_dec;
            pre_cnt <= pre_nxt;
            if (act) begin
                is_open <= 1'b1;
                row     <= act_row;
            end else if (pre) begin
                is_open <= 1'b0;
            end
        end
    end

    assign act_ok = (act_cnt == '0);
    assign rw_ok  = (rw_cnt == '0);
    assign pre_ok = (pre_cnt == '0);

endmodule

// File: rtl/ddr3_cmd_sched.sv
// Single-port DDR3 command scheduler: open-row tracking, core timing, ACT/RD/WR/PRE.
// Define DDR3_SCHED_REFRESH_EN to add periodic PREA/REF insertion.
module ddr3_cmd_sched
    import ddr3_sched_pkg::*;
#(
    parameter int T_RCD  = 5,
    parameter int T_RP   = 5,
    parameter int T_RAS  = 14,
    parameter int T_RTP  = 4,
    parameter int T_WTP  = 17,
    parameter int T_CCD  = 4,
    parameter int T_WTR  = 13,
    parameter int T_RFC  = 59,
    parameter int T_REFI = 4160
) (
    input  logic              ck,
    input  logic              reset,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    output logic              csbar,
    output logic              rasbar,
    output logic              casbar,
    output logic              webar,
    output logic [BANK_W-1:0] ba,
    output logic [ROW_W-1:0]  a,
    output logic              rd_issue,
    output logic              wr_issue,
    output logic              ref_issue
);

    localparam int CW = $clog2(tmax(T_REFI, tmax(T_RFC,
                        tmax(tmax(T_RCD, T_RP), tmax(T_RAS,
                        tmax(tmax(T_RTP, T_WTP), tmax(T_CCD, T_WTR))))))
                        + 1);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] L_CCD = CW'(T_CCD - 1);
    localparam logic [CW-1:0] L_WTR = CW'(T_WTR - 1);

    state_e            state;
    state_e            state_n;
    cmd_e              cmd;
    req_t              req_q;
    logic              accept;
    logic [BANK_W-1:0] sel;
    logic [CW-1:0]     ccd_cnt;
    logic [CW-1:0]     wtr_cnt;
    logic [BANK_W-1:0] ba_n;
    logic [ROW_W-1:0]  a_n;

    logic [NBANK-1:0]  b_open;
    logic [NBANK-1:0]  b_act_ok;
    logic [NBANK-1:0]  b_rw_ok;
    logic [NBANK-1:0]  b_pre_ok;
    logic [ROW_W-1:0]  b_row [NBANK];

    logic              ref_pending;
`ifdef DDR3_SCHED_REFRESH_EN
    logic              ref_clr;
    logic [CW-1:0]     ref_cnt;
    logic [CW-1:0]     wait_cnt;
`endif

    assign sel = req_q.bank;

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic mine;
        assign mine = (req_q.bank == BANK_W'(i));
        ddr3_bank_timer #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .T_RTP (T_RTP),
            .T_WTP (T_WTP),
            .CW    (CW)
        ) u_timer (
            .ck      (ck),
            .reset   (reset),
            .act     (mine && cmd == CMD_ACT),
            .rd      (mine && cmd == CMD_RD),
            .wr      (mine && cmd == CMD_WR),
            .pre     ((mine && cmd == CMD_PRE) || cmd == CMD_PREA),
            .act_row (req_q.row),
            .is_open (b_open[i]),
            .row     (b_row[i]),
            .act_ok  (b_act_ok[i]),
            .rw_ok   (b_rw_ok[i]),
            .pre_ok  (b_pre_ok[i])
        );
    end

    always_comb begin
        state_n   = state;
        cmd       = CMD_NOP;
        req_ready = 1'b0;
        accept    = 1'b0;
`ifdef DDR3_SCHED_REFRESH_EN
        ref_clr   = 1'b0;
`endif
        if (!init_done) begin
            cmd = CMD_DES;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ref_pending) begin
`ifdef DDR3_SCHED_REFRESH_EN
                        state_n = (|b_open) ? S_PREA : S_REF;
`endif
                    end else begin
                        req_ready = 1'b1;
                        if (req_valid) begin
                            accept = 1'b1;
                            if (!b_open[req_bank])
                                state_n = S_ACT;
                            else if (b_row[req_bank] == req_row)
                                state_n = S_COL;
                            else
                                state_n = S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (b_pre_ok[sel]) begin
                        cmd     = CMD_PRE;
                        state_n = S_ACT;
                    end
                end
                S_ACT: begin
                    if (b_act_ok[sel]) begin
                        cmd     = CMD_ACT;
                        state_n = S_COL;
                    end
                end
                S_COL: begin
                    if (b_rw_ok[sel] && ccd_cnt == '0 &&
                        (req_q.write || wtr_cnt == '0)) begin
                        cmd     = req_q.write ? CMD_WR : CMD_RD;
                        state_n = S_IDLE;
                    end
                end
`ifdef DDR3_SCHED_REFRESH_EN
                S_PREA: begin
                    if (&(b_pre_ok | ~b_open)) begin
                        cmd     = CMD_PREA;
                        state_n = S_REF;
                    end
                end
                // PREA reloads every bank's act counter, so this also covers T_RP
                S_REF: begin
                    if (&b_act_ok) begin
                        cmd     = CMD_REF;
                        state_n = S_RFC_WAIT;
                    end
                end
                S_RFC_WAIT: begin
                    if (wait_cnt == '0) begin
                        ref_clr = 1'b1;
                        state_n = S_IDLE;
                    end
                end
`endif
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ba_n = '0;
        a_n  = '0;
        case (cmd)
            CMD_ACT: begin
                ba_n = req_q.bank;
                a_n  = req_q.row;
            end
            CMD_RD, CMD_WR: begin
                ba_n = req_q.bank;
                a_n  = {4'b0100, req_q.col};
            end
            CMD_PRE:  ba_n = req_q.bank;
            CMD_PREA: a_n  = 14'h0400;
            default: ;
        endcase
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state   <= S_IDLE;
            req_q   <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
        end else begin
            state <= state_n;
            if (accept)
                req_q <= '{req_write, req_bank, req_row, req_col};
            if (cmd == CMD_RD || cmd == CMD_WR)
                ccd_cnt <= L_CCD;
            else if (ccd_cnt != '0)
                ccd_cnt <= ccd_cnt - ONE;
            if (cmd == CMD_WR)
                wtr_cnt <= L_WTR;
            else if (wtr_cnt != '0)
                wtr_cnt <= wtr_cnt - ONE;
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            {csbar, rasbar, casbar, webar} <= ENC_DES;
            ba       <= '0;
            a        <= '0;
            rd_issue <= 1'b0;
            wr_issue <= 1'b0;
        end else begin
            {csbar, rasbar, casbar, webar} <= cmd_enc(cmd);
            ba       <= ba_n;
            a        <= a_n;
            rd_issue <= (cmd == CMD_RD);
            wr_issue <= (cmd == CMD_WR);
        end
    end

`ifdef DDR3_SCHED_REFRESH_EN
    // a new expiry in the same cycle as the clear stays pending
    always_ff @(posedge ck) begin
        if (reset) begin
            ref_cnt     <= CW'(T_REFI);
            ref_pending <= 1'b0;
            wait_cnt    <= '0;
            ref_issue   <= 1'b0;
        end else begin
            ref_issue <= (cmd == CMD_REF);
            if (cmd == CMD_REF)
                wait_cnt <= CW'(T_RFC - 1);
            else if (wait_cnt != '0)
                wait_cnt <= wait_cnt - ONE;
            if (ref_clr)
                ref_pending <= 1'b0;
            if (!init_done) begin
                ref_cnt <= CW'(T_REFI);
            end else if (ref_cnt == '0) begin
                ref_cnt     <= CW'(T_REFI);
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt - ONE;
            end
        end
    end
`else
    assign ref_pending = 1'b0;
    assign ref_issue   = 1'b0;
`endif

endmodule
